// File: rtl/regfile_access_sequencer.sv
// Register-file port initiator: reads two operands, hands them to execute over
// valid/ready, then writes the returned result back with a single-cycle strobe.
module regfile_access_sequencer #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int READ_LAT = 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_rs,
   input  logic [ADDR_W-1:0] req_rt,
   input  logic [ADDR_W-1:0] req_rd,
   input  logic              req_wb,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [DATA_W-1:0] res_value,
   output logic [ADDR_W-1:0] rf_readA_addr,
   output logic [ADDR_W-1:0] rf_readB_addr,
   input  logic [DATA_W-1:0] rf_reg_A,
   input  logic [DATA_W-1:0] rf_reg_B,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_value,
   output logic              busy
);

   localparam int CNT_W = ($clog2(READ_LAT + 1) < 1) ? 1 : $clog2(READ_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_OPER  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic              wb_q, wb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_valid_q, op_valid_d;
   logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [DATA_W-1:0] wv_q, wv_d;

   always_comb begin
      state_d    = state_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      wb_d       = wb_q;
      cnt_d      = cnt_q;
      op_valid_d = op_valid_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      wr_d       = wr_q;
      wa_d       = wa_q;
      wv_d       = wv_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               rs_d    = req_rs;
               rt_d    = req_rt;
               rd_d    = req_rd;
               wb_d    = req_wb;
               cnt_d   = CNT_INIT;
               state_d = S_READ;
            end
         end
         S_READ: begin
            // Read addresses stay put in rs_q/rt_q until the file latency has elapsed.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               op_a_d     = rf_reg_A;
               op_b_d     = rf_reg_B;
               op_valid_d = 1'b1;
               state_d    = S_OPER;
            end
         end
         S_OPER: begin
            if (op_ready) begin
               op_valid_d = 1'b0;
               state_d    = wb_q ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            if (res_valid) begin
               wv_d    = res_value;
               wa_d    = rd_q;
               wr_d    = 1'b1;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            wr_d    = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            op_valid_d = 1'b0;
            wr_d       = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         wb_q       <= 1'b0;
         cnt_q      <= '0;
         op_valid_q <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         wr_q       <= 1'b0;
         wa_q       <= '0;
         wv_q       <= '0;
      end else begin
         state_q    <= state_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         wb_q       <= wb_d;
         cnt_q      <= cnt_d;
         op_valid_q <= op_valid_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         wr_q       <= wr_d;
         wa_q       <= wa_d;
         wv_q       <= wv_d;
      end
   end

   // Gated by RST_N so no request is accepted while reset is held.
   assign req_ready      = RST_N && (state_q == S_IDLE);
   assign res_ready      = (state_q == S_WAIT);
   assign busy           = (state_q != S_IDLE);
   assign op_valid       = op_valid_q;
   assign op_a           = op_a_q;
   assign op_b           = op_b_q;
   assign rf_readA_addr  = rs_q;
   assign rf_readB_addr  = rt_q;
   assign rf_write       = wr_q;
   assign rf_write_addr  = wa_q;
   assign rf_write_value = wv_q;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Bench: four sequencers (READ_LAT 0..3), each on a register-file model of matching
// latency, driven by directed and random transactions against a shadow register array.
module tb_regfile_access_sequencer;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;

   logic        req_valid [4], req_ready [4], req_wb [4];
   logic        op_valid [4], op_ready [4], res_valid [4], res_ready [4];
   logic        rf_write [4], busy [4];
   logic [2:0]  req_rs [4], req_rt [4], req_rd [4], ra [4], rb [4], wa [4];
   logic [15:0] op_a [4], op_b [4], res_value [4], rfA [4], rfB [4], wv [4];

   logic [15:0] file  [4][8];
   logic [15:0] model [4][8];
   logic [15:0] pipeA [4][4];
   logic [15:0] pipeB [4][4];

   logic        pl_we = 1'b0;
   int          pl_g = 0;
   logic [2:0]  pl_addr = '0;
   logic [15:0] pl_val = '0;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      regfile_access_sequencer #(.DATA_W(16), .ADDR_W(3), .READ_LAT(g)) u_dut (
         .CLK(CLK), .RST_N(RST_N),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_rs(req_rs[g]), .req_rt(req_rt[g]), .req_rd(req_rd[g]), .req_wb(req_wb[g]),
         .op_valid(op_valid[g]), .op_ready(op_ready[g]), .op_a(op_a[g]), .op_b(op_b[g]),
         .res_valid(res_valid[g]), .res_ready(res_ready[g]), .res_value(res_value[g]),
         .rf_readA_addr(ra[g]), .rf_readB_addr(rb[g]),
         .rf_reg_A(rfA[g]), .rf_reg_B(rfB[g]),
         .rf_write(rf_write[g]), .rf_write_addr(wa[g]), .rf_write_value(wv[g]),
         .busy(busy[g])
      );
   end

   // Register-file model: write at the edge, read through g pipeline stages.
   always_ff @(posedge CLK) begin
      for (int g = 0; g < 4; g++) begin
         if (rf_write[g]) file[g][wa[g]] <= wv[g];
         pipeA[g][1] <= file[g][ra[g]];
         pipeB[g][1] <= file[g][rb[g]];
         for (int k = 2; k < 4; k++) begin
            pipeA[g][k] <= pipeA[g][k-1];
            pipeB[g][k] <= pipeB[g][k-1];
         end
      end
      if (pl_we) file[pl_g][pl_addr] <= pl_val;
   end

   always_comb begin
      for (int g = 0; g < 4; g++) begin
         rfA[g] = (g == 0) ? file[g][ra[g]] : pipeA[g][g];
         rfB[g] = (g == 0) ? file[g][rb[g]] : pipeB[g][g];
      end
   end

   task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, g, obs, exp);
      end
   endtask

   task automatic preload(input int g, input logic [2:0] a, input logic [15:0] v);
      pl_we = 1'b1; pl_g = g; pl_addr = a; pl_val = v;
      @(negedge CLK);
      pl_we = 1'b0;
      model[g][a] = v;
   endtask

   task automatic run_txn(input int g, input logic [2:0] rs, input logic [2:0] rt,
                          input logic [2:0] rd, input logic wb, input logic [15:0] res,
                          input int hold, input int rdly, input logic glitch);
      logic [15:0] ea, eb;
      int n;
      ea = model[g][rs];
      eb = model[g][rt];
      chk("req_ready_idle", g, req_ready[g], 1);
      chk("busy_idle", g, busy[g], 0);
      req_valid[g] = 1'b1; req_rs[g] = rs; req_rt[g] = rt; req_rd[g] = rd; req_wb[g] = wb;
      @(negedge CLK);
      req_valid[g] = 1'b0;
      req_rs[g] = 3'($urandom); req_rt[g] = 3'($urandom); req_rd[g] = 3'($urandom);
      req_wb[g] = 1'($urandom);
      n = 1;
      while (op_valid[g] !== 1'b1 && n < 12) begin
         chk("read_addr_a", g, ra[g], rs);
         chk("read_addr_b", g, rb[g], rt);
         chk("req_ready_busy", g, req_ready[g], 0);
         res_valid[g] = glitch; res_value[g] = 16'($urandom);
         @(negedge CLK);
         n++;
      end
      res_valid[g] = 1'b0;
      chk("op_latency", g, n, g + 2);
      chk("op_a", g, op_a[g], ea);
      chk("op_b", g, op_b[g], eb);
      for (int i = 0; i < hold; i++) begin
         req_valid[g] = 1'b1; res_valid[g] = glitch; res_value[g] = 16'($urandom);
         @(negedge CLK);
         chk("op_valid_hold", g, op_valid[g], 1);
         chk("op_a_hold", g, op_a[g], ea);
         chk("op_b_hold", g, op_b[g], eb);
         chk("read_addr_hold", g, ra[g], rs);
         chk("req_ready_hold", g, req_ready[g], 0);
      end
      req_valid[g] = 1'b0; res_valid[g] = 1'b0;
      op_ready[g] = 1'b1;
      @(negedge CLK);
      op_ready[g] = 1'b0;
      chk("op_valid_drop", g, op_valid[g], 0);
      if (wb) begin
         for (int i = 0; i < rdly; i++) begin
            chk("res_ready_wait", g, res_ready[g], 1);
            chk("no_early_write", g, rf_write[g], 0);
            @(negedge CLK);
         end
         chk("res_ready", g, res_ready[g], 1);
         res_valid[g] = 1'b1; res_value[g] = res;
         @(negedge CLK);
         res_valid[g] = 1'b0; res_value[g] = 16'($urandom);
         chk("wr_pulse", g, rf_write[g], 1);
         chk("wr_addr", g, wa[g], rd);
         chk("wr_value", g, wv[g], res);
         chk("res_ready_write", g, res_ready[g], 0);
         model[g][rd] = res;
         @(negedge CLK);
         chk("wr_single", g, rf_write[g], 0);
      end
      chk("req_ready_back", g, req_ready[g], 1);
      chk("file_rd", g, file[g][rd], model[g][rd]);
   endtask

   // Brings instance g to WAIT_RES for a write-back request.
   task automatic go_wait(input int g, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
      int n;
      req_valid[g] = 1'b1; req_rs[g] = rs; req_rt[g] = rt; req_rd[g] = rd; req_wb[g] = 1'b1;
      @(negedge CLK);
      req_valid[g] = 1'b0;
      n = 0;
      while (op_valid[g] !== 1'b1 && n < 12) begin
         @(negedge CLK);
         n++;
      end
      chk("go_wait_op_valid", g, op_valid[g], 1);
      op_ready[g] = 1'b1;
      @(negedge CLK);
      op_ready[g] = 1'b0;
      chk("go_wait_res_ready", g, res_ready[g], 1);
   endtask

   task automatic check_reset_outputs(input int g);
      chk("rst_op_valid", g, op_valid[g], 0);
      chk("rst_op_a", g, op_a[g], 0);
      chk("rst_op_b", g, op_b[g], 0);
      chk("rst_rf_write", g, rf_write[g], 0);
      chk("rst_wr_addr", g, wa[g], 0);
      chk("rst_wr_value", g, wv[g], 0);
      chk("rst_read_a", g, ra[g], 0);
      chk("rst_read_b", g, rb[g], 0);
      chk("rst_req_ready", g, req_ready[g], 0);
      chk("rst_res_ready", g, res_ready[g], 0);
      chk("rst_busy", g, busy[g], 0);
   endtask

   initial begin
      for (int g = 0; g < 4; g++) begin
         req_valid[g] = 1'b0; req_rs[g] = '0; req_rt[g] = '0; req_rd[g] = '0; req_wb[g] = 1'b0;
         op_ready[g] = 1'b0; res_valid[g] = 1'b0; res_value[g] = '0;
      end
      repeat (3) @(negedge CLK);
      for (int g = 0; g < 4; g++) check_reset_outputs(g);
      RST_N = 1'b1;
      @(negedge CLK);
      for (int g = 0; g < 4; g++) chk("req_ready_after_rst", g, req_ready[g], 1);

      for (int g = 0; g < 4; g++)
         for (int a = 0; a < 8; a++) preload(g, 3'(a), 16'($urandom));
      preload(1, 3'd2, 16'h1234);
      preload(1, 3'd5, 16'hBEEF);

      run_txn(1, 3'd2, 3'd5, 3'd0, 1'b0, 16'h0000, 0, 0, 1'b0);
      run_txn(1, 3'd1, 3'd1, 3'd7, 1'b1, 16'hA5A5, 0, 0, 1'b0);
      run_txn(1, 3'd7, 3'd2, 3'd3, 1'b0, 16'h0000, 0, 0, 1'b0);
      run_txn(1, 3'd5, 3'd7, 3'd4, 1'b0, 16'h0000, 5, 0, 1'b0);
      run_txn(1, 3'd3, 3'd6, 3'd0, 1'b1, 16'h5A0F, 2, 3, 1'b1);

      go_wait(1, 3'd3, 3'd4, 3'd6);
      #2 RST_N = 1'b0;
      #1 check_reset_outputs(1);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("wait_rst_target", 1, file[1][6], model[1][6]);
      chk("wait_rst_ready", 1, req_ready[1], 1);

      go_wait(1, 3'd0, 3'd1, 3'd2);
      res_valid[1] = 1'b1; res_value[1] = 16'hDEAD;
      @(negedge CLK);
      res_valid[1] = 1'b0;
      chk("write_state_pulse", 1, rf_write[1], 1);
      #1 RST_N = 1'b0;
      #1 check_reset_outputs(1);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("write_rst_ready", 1, req_ready[1], 1);
      model[1][2] = file[1][2];

      for (int i = 0; i < 40; i++)
         run_txn(1, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      for (int g = 0; g < 4; g++)
         for (int i = 0; i < 10; i++)
            run_txn(g, 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
